// File: rtl/gdb_rsp_tx.sv
// GDB remote-serial-protocol packet framer: buffers a raw payload, emits
// $<escaped payload>#<checksum>, and optionally retransmits until acknowledged.
module gdb_rsp_tx #(
    parameter int BUF_DEPTH   = 256,
    parameter bit ACK_EN      = 1'b1,
    parameter int ACK_TIMEOUT = 1000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pld_vld,
    output logic       pld_rdy,
    input  logic [7:0] pld_dat,
    input  logic       pld_lst,
    input  logic       pld_emp,
    output logic       tx_vld,
    input  logic       tx_rdy,
    output logic [7:0] tx_dat,
    input  logic       ack_vld,
    input  logic [7:0] ack_dat,
    output logic       busy,
    output logic       err_ovf,
    output logic       err_nak
);

    localparam int IDX_W = $clog2(BUF_DEPTH);
    localparam int LEN_W = IDX_W + 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SOF, S_DATA, S_ESC, S_HASH, S_CKH, S_CKL, S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [7:0]         csum_q, csum_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic               err_ovf_q, err_ovf_d;
    logic               err_nak_q, err_nak_d;

    logic [7:0]         mem_q [BUF_DEPTH];
    logic               mem_we;
    logic [IDX_W-1:0]   mem_wa;
    logic [7:0]         mem_wd;

    logic               pld_fire;
    logic [7:0]         cur_byte;
    logic               cur_special;
    logic [LEN_W-1:0]   idx_inc;
    logic               last_byte;
    logic [TMR_W-1:0]   timer_inc;
    logic               ack_plus;
    logic               retry_due;
    logic               retry_exhausted;

    function automatic logic is_special(input logic [7:0] b);
        return (b == 8'h23) || (b == 8'h24) || (b == 8'h7d) || (b == 8'h2a);
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    assign pld_fire        = pld_vld & pld_rdy;
    assign cur_byte        = mem_q[idx_q[IDX_W-1:0]];
    assign cur_special     = is_special(cur_byte);
    assign idx_inc         = idx_q + LEN_W'(1);
    assign last_byte       = (idx_inc == len_q);
    assign timer_inc       = timer_q + TMR_W'(1);
    assign ack_plus        = ack_vld && (ack_dat == 8'h2b);
    assign retry_due       = (ack_vld && (ack_dat == 8'h2d)) || (timer_inc == TMR_W'(ACK_TIMEOUT));
    assign retry_exhausted = (retry_q == RTY_W'(MAX_RETRY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            csum_q    <= '0;
            timer_q   <= '0;
            retry_q   <= '0;
            err_ovf_q <= 1'b0;
            err_nak_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            err_ovf_q <= err_ovf_d;
            err_nak_q <= err_nak_d;
        end
    end

    // Payload storage needs no reset: len_q alone says which bytes are valid.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (pld_fire) state_d = pld_lst ? S_SOF : S_LOAD;
            S_LOAD: if (pld_fire && pld_lst) state_d = S_SOF;
            S_SOF:  if (tx_rdy) state_d = (len_q == '0) ? S_HASH : S_DATA;
            S_DATA: if (tx_rdy) state_d = cur_special ? S_ESC : (last_byte ? S_HASH : S_DATA);
            S_ESC:  if (tx_rdy) state_d = last_byte ? S_HASH : S_DATA;
            S_HASH: if (tx_rdy) state_d = S_CKH;
            S_CKH:  if (tx_rdy) state_d = S_CKL;
            S_CKL:  if (tx_rdy) state_d = ACK_EN ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (ack_plus)       state_d = S_IDLE;
                else if (retry_due) state_d = retry_exhausted ? S_IDLE : S_SOF;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pld_rdy = 1'b0;
        tx_vld  = 1'b0;
        tx_dat  = 8'h00;
        case (state_q)
            S_IDLE, S_LOAD: pld_rdy = !rst;
            S_SOF:  begin tx_vld = 1'b1; tx_dat = 8'h24; end
            S_DATA: begin tx_vld = 1'b1; tx_dat = cur_special ? 8'h7d : cur_byte; end
            S_ESC:  begin tx_vld = 1'b1; tx_dat = cur_byte ^ 8'h20; end
            S_HASH: begin tx_vld = 1'b1; tx_dat = 8'h23; end
            S_CKH:  begin tx_vld = 1'b1; tx_dat = hex_char(csum_q[7:4]); end
            S_CKL:  begin tx_vld = 1'b1; tx_dat = hex_char(csum_q[3:0]); end
            default: ;
        endcase
        busy    = (state_q != S_IDLE);
        err_ovf = err_ovf_q;
        err_nak = err_nak_q;
    end

    // The checksum restarts at every '$' so a retransmission recomputes it from the buffer.
    always_comb begin
        len_d     = len_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        err_ovf_d = err_ovf_q;
        err_nak_d = 1'b0;
        mem_we    = 1'b0;
        mem_wa    = len_q[IDX_W-1:0];
        mem_wd    = pld_dat;
        case (state_q)
            S_IDLE: if (pld_fire) begin
                err_ovf_d = 1'b0;
                csum_d    = '0;
                mem_wa    = '0;
                mem_we    = !pld_emp;
                len_d     = pld_emp ? '0 : LEN_W'(1);
            end
            S_LOAD: if (pld_fire && !pld_emp) begin
                if (len_q == LEN_W'(BUF_DEPTH)) begin
                    err_ovf_d = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    len_d  = len_q + LEN_W'(1);
                end
            end
            S_SOF: if (tx_rdy) begin
                idx_d  = '0;
                csum_d = '0;
            end
            S_DATA: if (tx_rdy) begin
                csum_d = csum_q + tx_dat;
                if (!cur_special) idx_d = idx_inc;
            end
            S_ESC: if (tx_rdy) begin
                csum_d = csum_q + tx_dat;
                idx_d  = idx_inc;
            end
            S_CKL: if (tx_rdy) timer_d = '0;
            S_WAIT: begin
                timer_d = timer_inc;
                if (ack_plus) begin
                    retry_d = '0;
                end else if (retry_due) begin
                    if (retry_exhausted) begin
                        retry_d   = '0;
                        err_nak_d = 1'b1;
                    end else begin
                        retry_d = retry_q + RTY_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gdb_rsp_tx.sv
// Directed bench for gdb_rsp_tx: framing, escaping, checksum, ack/retry,
// overflow truncation and reset behaviour against hand-computed byte streams.
module tb_gdb_rsp_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       pld_vld;
    logic       pld_rdy;
    logic [7:0] pld_dat;
    logic       pld_lst;
    logic       pld_emp;
    logic       tx_vld;
    logic       tx_rdy;
    logic [7:0] tx_dat;
    logic       ack_vld;
    logic [7:0] ack_dat;
    logic       busy;
    logic       err_ovf;
    logic       err_nak;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nak_count = 0;
    int nak_cyc = 0;
    int nak_base;
    int wait_i;
    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    logic [7:0] exp_q[$];

    gdb_rsp_tx #(
        .BUF_DEPTH(4),
        .ACK_EN(1'b1),
        .ACK_TIMEOUT(10),
        .MAX_RETRY(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pld_vld(pld_vld),
        .pld_rdy(pld_rdy),
        .pld_dat(pld_dat),
        .pld_lst(pld_lst),
        .pld_emp(pld_emp),
        .tx_vld(tx_vld),
        .tx_rdy(tx_rdy),
        .tx_dat(tx_dat),
        .ack_vld(ack_vld),
        .ack_dat(ack_dat),
        .busy(busy),
        .err_ovf(err_ovf),
        .err_nak(err_nak)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte transfers and nak pulses are sampled mid-cycle, where inputs are settled.
    always @(negedge clk) begin
        if (tx_vld === 1'b1 && tx_rdy === 1'b1) begin
            rx_q.push_back(tx_dat);
            rx_cyc.push_back(cyc);
        end
        if (err_nak === 1'b1) begin
            nak_count <= nak_count + 1;
            nak_cyc   <= cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] dat, input logic lst, input logic emp);
        int waited = 0;
        pld_vld = 1'b1;
        pld_dat = dat;
        pld_lst = lst;
        pld_emp = emp;
        while (waited < 50) begin
            @(negedge clk);
            if (pld_rdy === 1'b1) break;
            waited++;
        end
        checkOutput("pld_handshake", 32'(waited < 50), 32'd1);
        @(posedge clk); #1;
        pld_vld = 1'b0;
        pld_lst = 1'b0;
        pld_emp = 1'b0;
        pld_dat = 8'h00;
    endtask

    task automatic sendAck(input logic [7:0] b);
        ack_vld = 1'b1;
        ack_dat = b;
        @(posedge clk); #1;
        ack_vld = 1'b0;
        ack_dat = 8'h00;
    endtask

    task automatic waitBytes(input int n, input int budget, input bit toggle);
        bit         stalled;
        logic [7:0] held;
        int         i = 0;
        stalled = toggle && (tx_vld === 1'b1) && (tx_rdy === 1'b0);
        held    = tx_dat;
        while (rx_q.size() < n && i < budget) begin
            @(posedge clk); #1;
            if (stalled) checkOutput("tx_hold", 32'(tx_dat), 32'(held));
            if (toggle) tx_rdy = ~tx_rdy;
            stalled = toggle && (tx_vld === 1'b1) && (tx_rdy === 1'b0);
            held    = tx_dat;
            i++;
        end
        checkOutput("byte_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic checkPacket(input string tag, input int base);
        for (int i = 0; i < exp_q.size(); i++)
            checkOutput($sformatf("%s[%0d]", tag, i), 32'(rx_q[base + i]), 32'(exp_q[i]));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        rst     = 1'b1;
        pld_vld = 1'b0;
        pld_dat = 8'h00;
        pld_lst = 1'b0;
        pld_emp = 1'b0;
        tx_rdy  = 1'b1;
        ack_vld = 1'b0;
        ack_dat = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tx_vld", 32'(tx_vld), 32'd0);
        checkOutput("rst_tx_dat", 32'(tx_dat), 32'd0);
        checkOutput("rst_pld_rdy", 32'(pld_rdy), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err_ovf", 32'(err_ovf), 32'd0);
        checkOutput("rst_err_nak", 32'(err_nak), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_pld_rdy", 32'(pld_rdy), 32'd1);
        @(posedge clk); #1;

        $display("[TB] payload OK, immediate ack");
        rx_q.delete();
        applyStimulus(8'h4f, 1'b0, 1'b0);
        checkOutput("busy_rise", 32'(busy), 32'd1);
        applyStimulus(8'h4b, 1'b1, 1'b0);
        checkOutput("sof_latency_vld", 32'(tx_vld), 32'd1);
        checkOutput("sof_latency_dat", 32'(tx_dat), 32'h24);
        waitBytes(6, 40, 1'b0);
        exp_q = '{8'h24, 8'h4f, 8'h4b, 8'h23, 8'h39, 8'h61};
        checkPacket("ok_pkt", 0);
        checkOutput("wait_busy", 32'(busy), 32'd1);
        sendAck(8'h2b);
        checkOutput("ack_idle", 32'(busy), 32'd0);
        checkOutput("ok_no_extra", 32'(rx_q.size()), 32'd6);

        $display("[TB] stray ack, nak then ack");
        rx_q.delete();
        applyStimulus(8'h4f, 1'b0, 1'b0);
        applyStimulus(8'h4b, 1'b1, 1'b0);
        sendAck(8'h2b);
        waitBytes(6, 40, 1'b0);
        checkOutput("stray_ignored", 32'(busy), 32'd1);
        sendAck(8'h2d);
        waitBytes(12, 40, 1'b0);
        checkPacket("first_pkt", 0);
        checkPacket("resend_pkt", 6);
        sendAck(8'h2b);
        checkOutput("resend_idle", 32'(busy), 32'd0);
        checkOutput("resend_no_nak", 32'(nak_count), 32'd0);

        $display("[TB] empty payload");
        rx_q.delete();
        applyStimulus(8'h00, 1'b1, 1'b1);
        waitBytes(4, 20, 1'b0);
        exp_q = '{8'h24, 8'h23, 8'h30, 8'h30};
        checkPacket("empty_pkt", 0);
        sendAck(8'h2b);
        checkOutput("empty_idle", 32'(busy), 32'd0);

        $display("[TB] escaped byte with tx_rdy toggling");
        rx_q.delete();
        tx_rdy = 1'b0;
        applyStimulus(8'h23, 1'b1, 1'b0);
        waitBytes(6, 40, 1'b1);
        exp_q = '{8'h24, 8'h7d, 8'h03, 8'h23, 8'h38, 8'h30};
        checkPacket("esc_pkt", 0);
        tx_rdy = 1'b1;
        sendAck(8'h2b);
        checkOutput("esc_idle", 32'(busy), 32'd0);

        $display("[TB] timeout retries then abandon");
        rx_q.delete();
        rx_cyc.delete();
        nak_base = nak_count;
        applyStimulus(8'h4f, 1'b0, 1'b0);
        applyStimulus(8'h4b, 1'b1, 1'b0);
        waitBytes(12, 80, 1'b0);
        exp_q = '{8'h24, 8'h4f, 8'h4b, 8'h23, 8'h39, 8'h61};
        checkPacket("to_first", 0);
        checkPacket("to_resend", 6);
        checkOutput("to_gap", 32'(rx_cyc[6] - rx_cyc[5]), 32'd11);
        wait_i = 0;
        while (nak_count == nak_base && wait_i < 30) begin
            @(posedge clk); #1;
            wait_i++;
        end
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("nak_pulses", 32'(nak_count - nak_base), 32'd1);
        checkOutput("nak_timing", 32'(nak_cyc - rx_cyc[11]), 32'd11);
        checkOutput("nak_idle", 32'(busy), 32'd0);
        checkOutput("nak_no_third", 32'(rx_q.size()), 32'd12);

        $display("[TB] overflow truncation");
        rx_q.delete();
        applyStimulus(8'h41, 1'b0, 1'b0);
        applyStimulus(8'h42, 1'b0, 1'b0);
        applyStimulus(8'h43, 1'b0, 1'b0);
        applyStimulus(8'h44, 1'b0, 1'b0);
        applyStimulus(8'h45, 1'b0, 1'b0);
        applyStimulus(8'h46, 1'b1, 1'b0);
        checkOutput("ovf_set", 32'(err_ovf), 32'd1);
        waitBytes(8, 40, 1'b0);
        exp_q = '{8'h24, 8'h41, 8'h42, 8'h43, 8'h44, 8'h23, 8'h30, 8'h61};
        checkPacket("ovf_pkt", 0);
        sendAck(8'h2b);
        checkOutput("ovf_sticky", 32'(err_ovf), 32'd1);

        $display("[TB] reset mid-packet");
        rx_q.delete();
        applyStimulus(8'h41, 1'b0, 1'b0);
        checkOutput("ovf_cleared", 32'(err_ovf), 32'd0);
        applyStimulus(8'h42, 1'b0, 1'b0);
        applyStimulus(8'h43, 1'b1, 1'b0);
        waitBytes(2, 20, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_tx_vld", 32'(tx_vld), 32'd0);
        checkOutput("midrst_tx_dat", 32'(tx_dat), 32'd0);
        checkOutput("midrst_pld_rdy", 32'(pld_rdy), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_discard", 32'(rx_q.size()), 32'd2);
        rx_q.delete();
        applyStimulus(8'h7d, 1'b0, 1'b0);
        applyStimulus(8'h2a, 1'b1, 1'b0);
        waitBytes(8, 40, 1'b0);
        exp_q = '{8'h24, 8'h7d, 8'h5d, 8'h7d, 8'h0a, 8'h23, 8'h36, 8'h31};
        checkPacket("post_rst_pkt", 0);
        sendAck(8'h2b);
        checkOutput("post_rst_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gdb_rsp_tx.md
GDB_RSP_TX -- requirements
Module: gdb_rsp_tx

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 256, payload buffer size in bytes (power of 2).
REQ-002 SHALL have parameter ACK_EN, default 1, enables waiting for the '+'/'-' acknowledge.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 1000, clk cycles to wait for an ack before retransmitting.
REQ-004 SHALL have parameter MAX_RETRY, default 3, retransmissions before abandoning a packet.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports pld_vld/pld_rdy  input/output  1/1  payload stream handshake.
REQ-008 SHALL have ports pld_dat  input  8  raw (unescaped) payload byte; pld_lst  input  1  last beat; pld_emp  input  1  beat carries no byte (legal only with pld_lst).
REQ-009 SHALL have ports tx_vld/tx_rdy  output/input  1/1, tx_dat  output  8, framed byte stream toward the socket.
REQ-010 SHALL have ports ack_vld  input  1, ack_dat  input  8, bytes received from the GDB client.
REQ-011 SHALL have outputs busy 1 (not IDLE), err_ovf 1 (sticky, payload truncated), err_nak 1 (one-cycle pulse, packet abandoned).

Function
REQ-012 SHALL implement FSM IDLE, LOAD, SOF, DATA, ESC, HASH, CKH, CKL, WAIT.
REQ-013 pld_rdy SHALL be 1 only in IDLE and LOAD; a beat transfers on pld_vld&pld_rdy.
REQ-014 IDLE: a transfer stores the byte (unless pld_emp), clears err_ovf and the checksum, then goes to SOF if pld_lst else LOAD; LOAD stores bytes until the pld_lst transfer, then SOF.
REQ-015 Bytes beyond BUF_DEPTH SHALL be accepted and dropped, setting err_ovf; the packet is sent truncated.
REQ-016 tx_vld SHALL be 1 in SOF, DATA, ESC, HASH, CKH, CKL; a byte transfers on tx_vld&tx_rdy; tx_dat SHALL hold stable while tx_vld&!tx_rdy.
REQ-017 SOF SHALL send '$' (0x24), then DATA from buffer index 0, or HASH if the length is 0.
REQ-018 DATA: bytes 0x23 '#', 0x24 '$', 0x7d '}', 0x2a '*' SHALL be sent as 0x7d, then ESC sends byte^0x20; other bytes are sent verbatim.
REQ-019 Checksum SHALL be the mod-256 sum of every byte sent between '$' and '#', escape bytes included, in escaped form.
REQ-020 HASH SHALL send '#' (0x23), CKH the high nibble, CKL the low nibble, as lowercase ASCII hex ('0'-'9', 'a'-'f').
REQ-021 After CKL: if ACK_EN=0, go to IDLE; else go to WAIT, clear the timer, and discard any ack bytes received outside WAIT.
REQ-022 WAIT: ack '+' (0x2b) -> IDLE, retry counter cleared.
REQ-023 WAIT: ack '-' (0x2d) or timer reaching ACK_TIMEOUT -> SOF with retry+1, resending an identical packet from the buffer.
REQ-024 WAIT: when a retry is due with retry==MAX_RETRY -> IDLE, pulse err_nak, retry counter cleared.
REQ-025 WAIT SHALL ignore all other ack bytes.
REQ-026 Packet latency from the final pld transfer to '$' on tx_dat SHALL be 1 cycle; each output byte takes 1 cycle when tx_rdy=1.

Reset
REQ-027 Asserting rst in any state SHALL immediately force IDLE and clear the buffer length, checksum, timer and retry counter.
REQ-028 During and after rst, outputs SHALL be tx_vld=0, tx_dat=0x00, pld_rdy=0 while rst=1 (then 1), busy=0, err_ovf=0, err_nak=0.
REQ-029 A packet interrupted by rst SHALL be discarded, never resumed.

Verification
REQ-030 Payload "OK" (0x4f,0x4b), tx_rdy=1 -> tx bytes "$OK#9a", busy rises with the first pld transfer.
REQ-031 Single beat pld_emp=1, pld_lst=1 -> "$#00".
REQ-032 Payload 0x23 -> 0x24,0x7d,0x03,0x23,'8','0'; tx_rdy toggling each cycle -> same bytes, tx_dat stable while stalled.
REQ-033 "OK" then ack '-' -> "$OK#9a" resent; then ack '+' -> IDLE; a stray 0x2b before WAIT is ignored.
REQ-034 No ack, ACK_TIMEOUT=10, MAX_RETRY=1 -> two transmissions 10 cycles apart after CKL, then err_nak pulse and IDLE.
REQ-035 BUF_DEPTH=4, 6-byte payload -> err_ovf=1, 4 bytes framed; rst asserted mid-DATA -> tx_vld=0 at once, next packet framed correctly.
